// File: rtl/array_prod_if.sv
// Operand/result bundle for array_prod: two packed signed Q(QN.QM) vectors in, dot product out.
interface array_prod_if #(
  parameter int ELEMENTS = 8,
  parameter int QN       = 6,
  parameter int QM       = 11
);
  localparam int BITWIDTH = QN + QM + 1;

  logic [ELEMENTS*BITWIDTH-1:0] vec_a;
  logic [ELEMENTS*BITWIDTH-1:0] vec_b;
  logic                         data_ready;
  logic [BITWIDTH-1:0]          result;

  modport master (
    output vec_a,
    output vec_b,
    input  data_ready,
    input  result
  );

  modport slave (
    input  vec_a,
    input  vec_b,
    output data_ready,
    output result
  );
endinterface

// File: rtl/array_prod.sv
// Sequential signed fixed-point dot product, one MAC per clock, restarted by each reset release.
// Build option: define ARRAY_PROD_SATURATE_EN to clamp the result instead of wrapping it.
module array_prod #(
  parameter int ELEMENTS = 8,
  parameter int QN       = 6,
  parameter int QM       = 11
) (
  input  logic         clock,
  input  logic         reset,
  array_prod_if.slave  bus
);
  localparam int BITWIDTH = QN + QM + 1;
  localparam int PRODW    = 2 * BITWIDTH;
  localparam int IDXW     = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int ACCW     = PRODW + IDXW;

  localparam logic [IDXW-1:0]            LAST_IDX = IDXW'(ELEMENTS - 1);
  localparam logic signed [ACCW-1:0]     SAT_MAX  = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0]     SAT_MIN  = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0]        RES_MAX  = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0]        RES_MIN  = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FINISH = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                     state_r;
  state_t                     stateNext_s;
  logic                       macEn_s;
  logic                       finishEn_s;

  logic [IDXW-1:0]            elemIdx_r;
  logic signed [ACCW-1:0]     accum_r;
  logic [BITWIDTH-1:0]        result_r;
  logic                       dataReady_r;

  logic signed [BITWIDTH-1:0] elemA_s [ELEMENTS];
  logic signed [BITWIDTH-1:0] elemB_s [ELEMENTS];
  logic signed [BITWIDTH-1:0] opA_s;
  logic signed [BITWIDTH-1:0] opB_s;
  logic signed [PRODW-1:0]    product_s;
  logic signed [ACCW-1:0]     productExt_s;

  // Scale by 2^-QM (floor) and bring the accumulator down to operand width.
  function automatic logic [BITWIDTH-1:0] reduceRange(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] shifted;
    shifted = acc >>> QM;
`ifdef ARRAY_PROD_SATURATE_EN
    if (shifted > SAT_MAX) begin
      return RES_MAX;
    end else if (shifted < SAT_MIN) begin
      return RES_MIN;
    end else begin
      return BITWIDTH'(shifted);
    end
`else
    return BITWIDTH'(shifted);
`endif
  endfunction

  for (genvar i = 0; i < ELEMENTS; i++) begin : gUnpack
    assign elemA_s[i] = bus.vec_a[i*BITWIDTH +: BITWIDTH];
    assign elemB_s[i] = bus.vec_b[i*BITWIDTH +: BITWIDTH];
  end

  assign opA_s        = elemA_s[elemIdx_r];
  assign opB_s        = elemB_s[elemIdx_r];
  assign product_s    = PRODW'(opA_s) * PRODW'(opB_s);
  assign productExt_s = {{(ACCW-PRODW){product_s[PRODW-1]}}, product_s};

  // State register; reset doubles as the start command, so it lands directly in S_RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_RUN;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    stateNext_s = state_r;
    macEn_s     = 1'b0;
    finishEn_s  = 1'b0;
    case (state_r)
      S_RUN: begin
        macEn_s = 1'b1;
        if (elemIdx_r == LAST_IDX) begin
          stateNext_s = S_FINISH;
        end else begin
          stateNext_s = S_RUN;
        end
      end
      S_FINISH: begin
        finishEn_s  = 1'b1;
        stateNext_s = S_HOLD;
      end
      S_HOLD: begin
        stateNext_s = S_HOLD;
      end
      default: begin
        stateNext_s = S_HOLD;
      end
    endcase
  end

  // MAC datapath and registered outputs; the hold state freezes everything until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      elemIdx_r   <= '0;
      accum_r     <= '0;
      result_r    <= '0;
      dataReady_r <= 1'b0;
    end else begin
      if (macEn_s) begin
        accum_r   <= accum_r + productExt_s;
        elemIdx_r <= (elemIdx_r == LAST_IDX) ? elemIdx_r : elemIdx_r + IDXW'(1);
      end
      if (finishEn_s) begin
        result_r    <= reduceRange(accum_r);
        dataReady_r <= 1'b1;
      end
    end
  end

  assign bus.result     = result_r;
  assign bus.data_ready = dataReady_r;
endmodule

// File: tb/tb_array_prod.sv
// Directed bench for array_prod: arithmetic reference model plus per-cycle output comparison.
module tb_array_prod;
  localparam int N   = 8;
  localparam int QN  = 6;
  localparam int QM  = 11;
  localparam int BW  = QN + QM + 1;
  localparam int LAT = N + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  array_prod_if #(.ELEMENTS(N), .QN(QN), .QM(QM)) bus ();

  array_prod #(.ELEMENTS(N), .QN(QN), .QM(QM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int edgesSinceRel = 0;
  bit checkEn = 1'b0;
  logic [BW-1:0] expResult = '0;
  logic signed [BW-1:0] aEl [N];
  logic signed [BW-1:0] bEl [N];

  // Reference: exact integer dot product, floor-shift by QM, then wrap or clamp.
  function automatic logic [BW-1:0] modelDot();
    longint sum;
    longint shifted;
    sum = 0;
    for (int i = 0; i < N; i++) sum += longint'(aEl[i]) * longint'(bEl[i]);
    shifted = sum >>> QM;
`ifdef ARRAY_PROD_SATURATE_EN
    if (shifted > 64'sd131071) shifted = 64'sd131071;
    if (shifted < -64'sd131072) shifted = -64'sd131072;
`endif
    return shifted[BW-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyVecs();
    for (int i = 0; i < N; i++) begin
      bus.vec_a[i*BW +: BW] = aEl[i];
      bus.vec_b[i*BW +: BW] = bEl[i];
    end
  endtask

  task automatic fillAll(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int i = 0; i < N; i++) begin
      aEl[i] = a;
      bEl[i] = b;
    end
  endtask

  // Edges seen with reset low since the last reset edge.
  always @(posedge clock) begin
    if (reset) edgesSinceRel <= 0;
    else edgesSinceRel <= edgesSinceRel + 1;
  end

  // Every cycle: outputs must be reset values until LAT edges after release, then the model result.
  always @(negedge clock) begin
    if (checkEn) begin
      tests++;
      if (bus.data_ready !== (edgesSinceRel >= LAT)) begin
        fails++;
        $display("FAIL ready edge=%0d: got %0b expected %0b", edgesSinceRel, bus.data_ready, (edgesSinceRel >= LAT));
      end
      tests++;
      if (bus.result !== ((edgesSinceRel >= LAT) ? expResult : '0)) begin
        fails++;
        $display("FAIL result edge=%0d: got 0x%05h expected 0x%05h", edgesSinceRel, bus.result,
                 (edgesSinceRel >= LAT) ? expResult : '0);
      end
    end
  end

  // Reset for two edges, load the operands while reset is held, then release.
  task automatic startRun();
    reset = 1'b1;
    @(posedge clock);
    #1;
    applyVecs();
    expResult = modelDot();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, "_ready_seen"}, {31'd0, bus.data_ready}, 32'd1);
    check({name, "_latency"}, edgesSinceRel, LAT);
  endtask

  task automatic runCase(input string name, input logic [BW-1:0] lit);
    startRun();
    waitReady(name);
    check({name, "_model"}, expResult, lit);
    check({name, "_result"}, bus.result, lit);
  endtask

  initial begin
    fillAll(18'h00000, 18'h00000);
    applyVecs();
    repeat (2) @(posedge clock);
    #1;
    checkEn = 1'b1;
    check("reset_ready", {31'd0, bus.data_ready}, 32'd0);
    check("reset_result", bus.result, 32'd0);

    // Case 1 and Case 6: 8 * 0.5 * 1.0 = 4.0, then inputs change without reset.
    fillAll(18'h00400, 18'h00800);
    runCase("case1", 18'h02000);
    for (int i = 0; i < N; i++) bus.vec_b[i*BW +: BW] = 18'h00000;
    repeat (5) @(negedge clock);
    check("case6_result", bus.result, 32'h02000);
    check("case6_ready", {31'd0, bus.data_ready}, 32'd1);

    // Case 5: reset re-asserted on edge 4 of a run.
    fillAll(18'h00400, 18'h00800);
    startRun();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("case5_abort_ready", {31'd0, bus.data_ready}, 32'd0);
    check("case5_abort_result", bus.result, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    waitReady("case5");
    check("case5_result", bus.result, 32'h02000);

    fillAll(18'h00400, 18'h3F800);
    runCase("case2", 18'h3E000);
`ifdef ARRAY_PROD_SATURATE_EN
    fillAll(18'h0F800, 18'h0F800);
    runCase("case3", 18'h1FFFF);
    fillAll(18'h0F800, 18'h30800);
    runCase("case3neg", 18'h20000);
`else
    fillAll(18'h0F800, 18'h0F800);
    runCase("case3", 18'h04000);
`endif
    fillAll(18'h00001, 18'h00001);
    runCase("case4_pos", 18'h00000);
    fillAll(18'h3FFFF, 18'h00001);
    runCase("case4_neg", 18'h3FFFF);

    // Distinct elements: sum((i+1) * -0.5) = -18.0.
    for (int i = 0; i < N; i++) begin
      aEl[i] = BW'((i + 1) * 2048);
      bEl[i] = 18'h3FC00;
    end
    runCase("ramp", 18'h37000);

    // Small random operands that stay in range; model-checked every cycle.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        aEl[i] = BW'($signed($urandom_range(8191, 0)) - 4096);
        bEl[i] = BW'($signed($urandom_range(8191, 0)) - 4096);
      end
      startRun();
      waitReady("rand");
      repeat (2) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
